// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared types and sizes for the round-robin decoder arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_decoder_arbiter_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] sel;
  logic             en;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             timeout;

  modport master (output req, input sel, en, grant, busy, timeout);
  modport slave  (input req, output sel, en, grant, busy, timeout);

endinterface

// File: rtl/rr_decoder_arbiter_pick.sv
// Round-robin pick: first set request bit at or after ptr, wrapping mod N_REQ.
module rr_priority_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   offset;

  // Doubling the vector turns the rotate-right into a plain part-select.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_REQ];

  always_comb begin
    offset = '0;
    valid  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = IDX_W'(i);
        valid  = 1'b1;
      end
    end
  end

  assign idx = offset + ptr;

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder stage between 8 requesters,
// with optional hold timeout and a one-cycle dead gap between owners.
module rr_decoder_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_decoder_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [IDX_W-1:0] sel_q;
  logic             en_q;
  logic             timeout_q;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             owner_req;
  logic             hold_expired;

  rr_priority_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign owner_req    = bus.req[sel_q];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            sel_q    <= pick_idx;
            en_q     <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + CNT_W'(1);
          // A release on the expiry cycle takes precedence, so no timeout pulse.
          if (!owner_req || hold_expired) begin
            en_q      <= 1'b0;
            ptr       <= sel_q + IDX_W'(1);
            timeout_q <= owner_req;
            state     <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          en_q  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.en      = en_q;
  assign bus.timeout = timeout_q;
  assign bus.busy    = (state != IDLE);
  assign bus.grant   = en_q ? (N_REQ'(1) << sel_q) : '0;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench: three arbiters (MAX_HOLD 16, 4, 0) against a cycle-level
// reference model of the ownership rules.
module tb_rr_decoder_arbiter;

  typedef struct packed {
    logic [2:0] sel;
    logic       en;
    logic       busy;
    logic       to;
    logic [7:0] grant;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_decoder_arbiter_if b0 ();
  rr_decoder_arbiter_if b1 ();
  rr_decoder_arbiter_if b2 ();

  rr_decoder_arbiter #(.MAX_HOLD(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
  rr_decoder_arbiter #(.MAX_HOLD(4))  u1 (.clk(clk), .rst(rst), .bus(b1));
  rr_decoder_arbiter #(.MAX_HOLD(0))  u2 (.clk(clk), .rst(rst), .bus(b2));

  logic [7:0] tb_req [3];
  assign b0.req = tb_req[0];
  assign b1.req = tb_req[1];
  assign b2.req = tb_req[2];

  exp_t dut_out [3];
  assign dut_out[0] = {b0.sel, b0.en, b0.busy, b0.timeout, b0.grant};
  assign dut_out[1] = {b1.sel, b1.en, b1.busy, b1.timeout, b1.grant};
  assign dut_out[2] = {b2.sel, b2.en, b2.busy, b2.timeout, b2.grant};

  // Reference model: phase 0 idle, 1 owned, 2 gap; held = owned cycles shown so far.
  int m_phase [3];
  int m_owner [3];
  int m_nxt   [3];
  int m_held  [3];
  int maxh    [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int tests = 0;
  int fails = 0;

  task automatic model_step(input int k, input logic [7:0] r, output exp_t e);
    bit to;
    bit found;
    to = 1'b0;
    if (rst) begin
      m_phase[k] = 0; m_owner[k] = 0; m_nxt[k] = 0; m_held[k] = 0;
    end else begin
      case (m_phase[k])
        0: begin
          found = 1'b0;
          for (int j = 0; j < 8; j++) begin
            if (!found && r[(m_nxt[k] + j) % 8]) begin
              found = 1'b1;
              m_owner[k] = (m_nxt[k] + j) % 8;
            end
          end
          if (found) begin
            m_phase[k] = 1;
            m_held[k]  = 1;
          end
        end
        1: begin
          if (!r[m_owner[k]]) begin
            m_phase[k] = 2;
            m_nxt[k]   = (m_owner[k] + 1) % 8;
          end else if (maxh[k] != 0 && m_held[k] == maxh[k]) begin
            m_phase[k] = 2;
            m_nxt[k]   = (m_owner[k] + 1) % 8;
            to = 1'b1;
          end else begin
            m_held[k] = m_held[k] + 1;
          end
        end
        default: m_phase[k] = 0;
      endcase
    end
    e.sel   = 3'(m_owner[k]);
    e.en    = (m_phase[k] == 1);
    e.busy  = (m_phase[k] != 0);
    e.to    = to;
    e.grant = (m_phase[k] == 1) ? (8'd1 << m_owner[k]) : 8'd0;
  endtask

  // One clock: predict the outputs after this edge from the req it sampled,
  // then present the next request vectors.
  task automatic cycle(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
    exp_t e;
    @(posedge clk);
    #1;
    model_step(0, tb_req[0], e); q0.push_back(e);
    model_step(1, tb_req[1], e); q1.push_back(e);
    model_step(2, tb_req[2], e); q2.push_back(e);
    tb_req[0] = r0;
    tb_req[1] = r1;
    tb_req[2] = r2;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      bit   have;
      have = 1'b0;
      case (k)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (have) begin
        tests++;
        if (dut_out[k] !== e) begin
          fails++;
          $display("FAIL outputs[%0d] t=%0t got sel=%0d en=%b busy=%b timeout=%b grant=%h, expected sel=%0d en=%b busy=%b timeout=%b grant=%h",
                   k, $time, dut_out[k].sel, dut_out[k].en, dut_out[k].busy, dut_out[k].to, dut_out[k].grant,
                   e.sel, e.en, e.busy, e.to, e.grant);
        end
      end
    end
  end

  task automatic async_reset_check(input logic [7:0] r);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (dut_out[k] !== '0) begin
        fails++;
        $display("FAIL async_rst[%0d] got outputs=%h, expected 0", k, dut_out[k]);
      end
    end
    cycle(r, r, r);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    logic [7:0] nr [3];
    int x;
    maxh[0] = 16; maxh[1] = 4; maxh[2] = 0;
    for (int k = 0; k < 3; k++) begin
      tb_req[k] = 8'h00;
      m_phase[k] = 0; m_owner[k] = 0; m_nxt[k] = 0; m_held[k] = 0;
    end
    repeat (3) cycle(8'h00, 8'h00, 8'h00);
    rst = 1'b0;

    // Directed: wrap-around, round-robin with owner drops, timeouts,
    // simultaneous release/expiry, unlimited hold.
    for (int i = 0; i < 300; i++) begin
      if (i < 3)       r0 = 8'h40;
      else if (i < 4)  r0 = 8'h00;
      else if (i < 80) r0 = 8'h41;
      else begin
        r0 = 8'h81;
        if (m_phase[0] == 1 && m_held[0] >= 3) r0 = r0 & ~(8'd1 << m_owner[0]);
      end
      if (i < 20)      r1 = 8'h08;
      else if (i < 40) r1 = 8'h18;
      else if (i < 45) r1 = 8'h00;
      else if (i < 49) r1 = 8'h08;
      else if (i < 50) r1 = 8'h00;
      else             r1 = 8'h81;
      r2 = 8'h02;
      cycle(r0, r1, r2);
    end

    repeat (6) cycle(8'h04, 8'h04, 8'h04);
    async_reset_check(8'h04);
    repeat (6) cycle(8'h04, 8'h04, 8'h04);

    // Randomized traffic with occasional owner drops and idle periods.
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 3; k++) begin
        x = $urandom_range(0, 99);
        if (x < 60)      nr[k] = tb_req[k];
        else if (x < 72) nr[k] = 8'h00;
        else if (x < 85) nr[k] = tb_req[k] & ~(8'd1 << m_owner[k]);
        else             nr[k] = 8'($urandom);
      end
      cycle(nr[0], nr[1], nr[2]);
      if (i == 700) async_reset_check(8'h00);
    end

    repeat (4) cycle(8'h00, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    tests++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending, expected 0", q0.size() + q1.size() + q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
